// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the operand-forwarding / load-use hazard unit.
//   STOP / NO_STOP : encoding of a single bit of the pipeline stall bus
//   DEF_DW/DEF_AW  : default data and register-address widths
//   sliceField     : extracts field idx (width w) from a packed port vector
// ---------------------------------------------------------------------------
package fwd_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;

    // Widest packed vector sliceField accepts; callers zero-extend into it.
    localparam int SLICE_MAX = 1024;

    // Returns field idx of width w (w <= 64) from a packed vector whose
    // fields are laid out as [idx*w +: w]. Callers cast the result down to
    // the field width they need.
    function automatic logic [63:0] sliceField(input logic [SLICE_MAX-1:0] vec,
                                               input int idx,
                                               input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return 64'(vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
// One register read port of the bypass unit: priority match of the read
// address against every forwarding source, data select and hazard flag.
//   i_rdAddr    : decode-stage read address of this port
//   i_srcWe     : per-source write enable
//   i_srcWaddr  : per-source destination address, [s*AW +: AW]
//   i_srcWdata  : per-source data, [s*DW +: DW]
//   i_srcRdy    : per-source data valid (0 = load data still outstanding)
//   o_sel       : some source matches this port
//   o_data      : data of the winning (youngest) source, 0 when no match
//   o_hazard    : the winning source's data is not ready yet
// ---------------------------------------------------------------------------
module fwd_match #(
    parameter int NUM_STAGES = 3,
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic [AW-1:0]            i_rdAddr,
    input  logic [NUM_STAGES-1:0]    i_srcWe,
    input  logic [NUM_STAGES*AW-1:0] i_srcWaddr,
    input  logic [NUM_STAGES*DW-1:0] i_srcWdata,
    input  logic [NUM_STAGES-1:0]    i_srcRdy,
    output logic                     o_sel,
    output logic [DW-1:0]            o_data,
    output logic                     o_hazard
);

    logic w_zeroBlock;

    // The hard-wired zero register is never forwarded when ZERO_REG is set.
    assign w_zeroBlock = (ZERO_REG != 0) && (i_rdAddr == '0);

    // Walk from the oldest source to the youngest so a younger hit simply
    // overwrites an older one; the survivor is the highest-priority match.
    // Only the winner's ready bit matters, so a ready younger source hides
    // an unready older one.
    always_comb begin
        o_sel    = 1'b0;
        o_data   = '0;
        o_hazard = 1'b0;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            if (i_srcWe[s] && (i_srcWaddr[s*AW +: AW] == i_rdAddr) && !w_zeroBlock) begin
                o_sel    = 1'b1;
                o_data   = i_srcWdata[s*DW +: DW];
                o_hazard = !i_srcRdy[s];
            end
        end
    end

endmodule

// File: rtl/fwd_bypass_n.sv
// ---------------------------------------------------------------------------
// fwd_bypass_n
// Parametrised operand-forwarding and load-use hazard unit.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   flush             : pipeline flush, clears the EX-boundary registers
//   stall             : stall bus; bit STALL_IDX guards this boundary
//   rd_addr           : NUM_RD read addresses, port i at [i*AW +: AW]
//   src_we/waddr/wdata/rdy : NUM_STAGES forwarding sources, 0 = youngest
//   clr_cnt           : synchronous clear of the stall counter
//   stallreq_for_load : combinational load-use stall request
//   fwd_sel/fwd_data  : registered forward select / data per port
//   stall_cnt         : saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module fwd_bypass_n
    import fwd_pkg::*;
#(
    parameter int NUM_RD     = 2,
    parameter int NUM_STAGES = 3,
    parameter int DW         = DEF_DW,
    parameter int AW         = DEF_AW,
    parameter int STALL_W    = 6,
    parameter int STALL_IDX  = 3,
    parameter int ZERO_REG   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [STALL_W-1:0]       stall,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    input  logic [NUM_STAGES-1:0]    src_we,
    input  logic [NUM_STAGES*AW-1:0] src_waddr,
    input  logic [NUM_STAGES*DW-1:0] src_wdata,
    input  logic [NUM_STAGES-1:0]    src_rdy,
    input  logic                     clr_cnt,
    output logic                     stallreq_for_load,
    output logic [NUM_RD-1:0]        fwd_sel,
    output logic [NUM_RD*DW-1:0]     fwd_data,
    output logic [31:0]              stall_cnt
);

    logic [NUM_RD-1:0]    w_sel;
    logic [NUM_RD*DW-1:0] w_data;
    logic [NUM_RD-1:0]    w_hazard;
    logic                 w_bubble;
    logic                 w_unusedStall;

    logic [NUM_RD-1:0]    r_sel;
    logic [NUM_RD*DW-1:0] r_data;
    logic [31:0]          r_stallCnt;

    // Only two stall bits matter here; the rest of the bus is folded away.
    assign w_unusedStall = ^stall;

    // One matcher per read port, all looking at the same source set.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [AW-1:0] w_rdAddr;
        assign w_rdAddr = AW'(sliceField(SLICE_MAX'(rd_addr), i, AW));

        fwd_match #(
            .NUM_STAGES (NUM_STAGES),
            .DW         (DW),
            .AW         (AW),
            .ZERO_REG   (ZERO_REG)
        ) u_match (
            .i_rdAddr   (w_rdAddr),
            .i_srcWe    (src_we),
            .i_srcWaddr (src_waddr),
            .i_srcWdata (src_wdata),
            .i_srcRdy   (src_rdy),
            .o_sel      (w_sel[i]),
            .o_data     (w_data[i*DW +: DW]),
            .o_hazard   (w_hazard[i])
        );
    end

    assign stallreq_for_load = |w_hazard;

    // This stage stopped while the next one keeps going: a bubble must be
    // inserted, otherwise the next stage would consume the same operands twice.
    assign w_bubble = (stall[STALL_IDX] == STOP) && (stall[STALL_IDX+1] == NO_STOP);

    // EX-boundary registers: flush beats everything, then bubble insertion,
    // then a normal load; when both stages are stopped the values are frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel  <= '0;
            r_data <= '0;
        end else if (flush || w_bubble) begin
            r_sel  <= '0;
            r_data <= '0;
        end else if (stall[STALL_IDX] == NO_STOP) begin
            r_sel  <= w_sel;
            r_data <= w_data;
        end
    end

    // Performance counter of load-use stall cycles. A flushed cycle is not
    // charged, clear has priority, and the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (clr_cnt) begin
            r_stallCnt <= '0;
        end else if (stallreq_for_load && !flush && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign fwd_sel   = r_sel;
    assign fwd_data  = r_data;
    assign stall_cnt = r_stallCnt;

endmodule

// File: doc/fwd_bypass_n.md
# fwd_bypass_n

Parametrised operand-forwarding and load-use hazard unit for the in-order pipeline; successor of the fixed 2-port/3-stage bypass. Compares NUM_RD decode-stage register read addresses against NUM_STAGES downstream write-back sources, selects the youngest matching source per port, and registers the result into the EX boundary under the pipeline stall/flush rules. Raises a combinational load-use stall request when the winning source's data is not yet valid, and keeps a saturating count of load-use stall cycles for performance analysis.

## Interface
- NUM_RD, 2: number of register read ports.
- NUM_STAGES, 3: number of forwarding sources; index 0 is the youngest (EX) and has the highest priority.
- DW, 32: data width.
- AW, 5: register address width.
- STALL_W, 6: width of the stall bus.
- STALL_IDX, 3: stall bit guarding this boundary; STALL_IDX+1 is the next stage. Must be < STALL_W-1.
- ZERO_REG, 1: when 1, address 0 never matches.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  pipeline flush.
- stall  in  STALL_W  stall bus; Stop=1, NoStop=0.
- rd_addr  in  NUM_RD*AW  read address for port i at [i*AW +: AW].
- src_we  in  NUM_STAGES  source write enable.
- src_waddr  in  NUM_STAGES*AW  source destination address.
- src_wdata  in  NUM_STAGES*DW  source data.
- src_rdy  in  NUM_STAGES  source data valid; 0 for a load whose data has not returned.
- clr_cnt  in  1  synchronous clear of stall_cnt.
- stallreq_for_load  out  1  combinational load-use stall request.
- fwd_sel  out  NUM_RD  registered forward-select per port.
- fwd_data  out  NUM_RD*DW  registered forwarded data per port.
- stall_cnt  out  32  saturating load-use stall-cycle counter.

## Operation
- Match: hit[i][s] = src_we[s] & (rd_addr[i] == src_waddr[s]) & ~(ZERO_REG & rd_addr[i] == 0).
- Winner per port: the lowest s with hit[i][s]. sel_i = |hit[i]. data_i = src_wdata[winner], or 0 when there is no hit.
- Hazard per port: a hit whose winner has src_rdy = 0. Only the winner is checked; an older unready match shadowed by a younger ready one is not a hazard.
- stallreq_for_load = OR of the per-port hazards. Purely combinational, independent of the registers.
- Register update, in priority order:
  - flush = 1: clear all.
  - stall[STALL_IDX] = Stop and stall[STALL_IDX+1] = NoStop: clear all (bubble).
  - stall[STALL_IDX] = NoStop: load sel_i/data_i.
  - Otherwise: hold.
- stall_cnt:
  - clr_cnt = 1: set to 0. Clear wins over increment.
  - Else if stallreq_for_load & ~flush: increment, saturating at 0xFFFF_FFFF.
  - Else: hold.

## Timing
- Reset (rst_n low, asynchronous): fwd_sel = 0, fwd_data = 0, stall_cnt = 0. Outputs stay at reset values until the first rising edge after release.
- fwd_sel/fwd_data: one-cycle latency from rd_addr/src_* to the output.
- stallreq_for_load: zero-cycle latency, valid within the same cycle as its inputs.
- Simultaneous flush and stall: flush wins, registers clear.
- Stalled at both STALL_IDX and STALL_IDX+1: registers hold their values indefinitely, even if the sources change.
- Reset asserted mid-stall: all state clears immediately; no stall history is retained.
- Counter at 0xFFFF_FFFF with a stall pending: stays at 0xFFFF_FFFF.
- Counter at 0xFFFF_FFFF with clr_cnt = 1: becomes 0.

## Structure
- Package fwd_pkg:
  - Stop/NoStop constants.
  - Default DW/AW.
  - Function that slices a packed port vector.
- Sub-module fwd_match:
  - Handles one read port: NUM_STAGES-way priority match, data select, hazard bit.
  - Instantiated NUM_RD times by generate.
- Top level holds the registers, the hazard OR and the counter.

## Test plan
- Priority:
  - Stimulus: rd_addr[0] = 5; src 0 and src 2 both write r5 with 0xAAAA_0000 and 0x5555_0000; all rdy = 1; no stall.
  - Response: next cycle fwd_sel[0] = 1, fwd_data[0] = 0xAAAA_0000; stallreq_for_load = 0.
- Load-use:
  - Stimulus: rd_addr[1] = 7; src 0 writes r7 with src_rdy[0] = 0 for 3 cycles.
  - Response: stallreq_for_load = 1 for those 3 cycles; stall_cnt = 3.
  - Stimulus: same, but src 0 is ready and src 1 writes r7 with rdy = 0.
  - Response: no stall (shadowed).
- Zero register:
  - Stimulus: rd_addr[0] = 0; src 0 writes r0 with 0x1234.
  - Response: fwd_sel[0] = 0, fwd_data[0] = 0, no stall.
  - Stimulus: repeat with ZERO_REG = 0.
  - Response: fwd_sel[0] = 1, fwd_data[0] = 0x1234.
- Stall/bubble/flush:
  - Stimulus: stall = 6'b001000.
  - Response: registers clear.
  - Stimulus: stall = 6'b011000.
  - Response: registers hold the prior 0xDEAD_BEEF.
  - Stimulus: flush = 1 together with stall = 6'b011000.
  - Response: registers clear.
- Counter:
  - Stimulus: force the count to 0xFFFF_FFFE; hold the stall for 3 cycles.
  - Response: count reads 0xFFFF_FFFF.
  - Stimulus: clr_cnt = 1 with the stall still pending.
  - Response: count 0.
- Async reset:
  - Stimulus: drop rst_n mid-cycle with fwd_sel = 2'b11.
  - Response: all outputs 0 before the next clock edge.
- Parameter sweep:
  - Stimulus: NUM_RD = 3, NUM_STAGES = 5; random addresses, compared against a reference model for 10k cycles.
  - Response: zero mismatches.
